xnor_pop_sequencer: RTL and testbench
=====================================

Name: xnor_pop_sequencer

Overview:
- Controller that runs one binary-neuron evaluation over K chunks of N bits each.
- Issues reads to the external activation/weight chunk buffer and tracks the fixed-latency returns.
- XNOR-popcounts each returned chunk, accumulates the counts, compares the total against a threshold and presents the result on a valid/ready handshake.
- Sits between the chunk buffers and the downstream result consumer and replaces free-running accumulation with an explicit start/done sequence.

Parameters:
N, 256, bits per chunk (xi/wi width)
POP, 16, accumulator and threshold width
AW, 3, chunk address width; max K = 2^AW
RD_LAT, 2, buffer read latency in cycles (1..4); data is valid RD_LAT cycles after mem_re

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous, active-high reset
start  in  1  request a new evaluation; sampled only in IDLE
num_chunks  in  AW+1  K, latched on start; values above 2^AW are clamped to 2^AW
thresh  in  POP  threshold, latched on start
busy  out  1  high in every state except IDLE
mem_re  out  1  buffer read enable
mem_addr  out  AW  buffer read address
mem_xi  in  N  returned activation chunk
mem_wi  in  N  returned weight chunk
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
res_out  out  1  1 when res_sum > latched thresh (strict)
res_sum  out  POP  accumulated popcount

Behaviour:
- Reset: state IDLE; busy, mem_re, res_valid, res_out = 0; mem_addr, res_sum, accumulator, issue counter, return tracker = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches K and thresh and clears the accumulator.
  - K>0: go to ISSUE.
  - K=0: go directly to DONE with sum 0.
- ISSUE: mem_re=1 for exactly K consecutive cycles; mem_addr = 0,1,..,K-1. After the last issue, go to DRAIN.
- Return tracking: an RD_LAT-deep valid shift register tags each issue. Mem data is used only when its tag is set; mem_xi/mem_wi are ignored otherwise.
- Datapath pipeline:
  - Stage 1 registers popcount(~(mem_xi ^ mem_wi)), width clog2(N)+1.
  - Stage 2 adds that count to the accumulator. The accumulator saturates at 2^POP-1 and never wraps.
- DRAIN: stays until the tracker and the pipeline are empty, then goes to DONE. In the same edge, res_sum <= accumulator and res_out <= (accumulator > thresh).
- Latency:
  - K>0: res_valid rises after rising edge number K+RD_LAT+2, counting the edge that accepted start as edge 0.
  - K=0: res_valid rises after edge 1.
- DONE: res_valid=1. res_sum and res_out are held stable until a cycle where res_ready=1; on that edge, go to IDLE and clear res_valid. res_sum and res_out keep their values in IDLE.
- start outside IDLE is ignored. It is not queued.
- start in the same cycle that DONE completes its handshake is ignored; start is sampled only while already in IDLE.
- Reset mid-operation returns to IDLE immediately. In-flight returns are discarded. The next evaluation is unaffected by stale data.

Optional Feature:
- Macro XNOR_SEQ_PERF_EN.
- Defined: adds output port perf_cycles [15:0].
  - Counts clk cycles spent outside IDLE for the current evaluation, saturating at 16'hFFFF.
  - Cleared when start is accepted; frozen in DONE and IDLE.
  - Reset value 0.
- Undefined: no port, no counter logic.

Test Plan:
- K=1, thresh=255, xi=wi=all-ones -> res_sum=256, res_out=1, res_valid after edge 5 (RD_LAT=2), mem_addr=0 issued for one cycle.
- K=8, every chunk xi=~wi, thresh=0 -> res_sum=0, res_out=0; mem_addr sequence 0..7 on 8 consecutive mem_re cycles.
- K=3, chunk pops 100/50/6, thresh=156 -> res_sum=156, res_out=0. Rerun with thresh=155 -> res_out=1.
- Backpressure: res_ready=0 for 5 cycles in DONE, with a start pulse in cycle 2 -> res_valid, res_sum, res_out held; start ignored; one IDLE cycle after handshake before a new start is taken.
- num_chunks=0, thresh=0 -> res_valid after edge 1, res_sum=0, res_out=0, no mem_re. num_chunks=9 -> clamped, exactly 8 reads.
- rstn pulsed during DRAIN of a K=4 run, then K=1 with pop 10, thresh=5 -> res_sum=10, res_out=1. With XNOR_SEQ_PERF_EN, perf_cycles=5 for the K=1 run.

Source files
------------

// File: rtl/xnor_pop_sequencer_if.sv
// Bus bundle between xnor_pop_sequencer (master) and its environment (slave):
// command inputs, chunk-buffer read port, result port and debug state.
interface xnor_pop_sequencer_if #(
   parameter int N   = 256,
   parameter int POP = 16,
   parameter int AW  = 3
);
   logic          start;
   logic [AW:0]   num_chunks;
   logic [POP-1:0] thresh;
   logic          busy;
   logic [1:0]    dbg_state;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [N-1:0]  mem_xi;
   logic [N-1:0]  mem_wi;
   // Result handshake: res_valid stays high with res_sum/res_out stable until
   // a cycle with res_ready=1; the transfer completes on that rising edge.
   logic          res_valid;
   logic          res_ready;
   logic          res_out;
   logic [POP-1:0] res_sum;

   modport master (
      input  start, num_chunks, thresh, mem_xi, mem_wi, res_ready,
      output busy, dbg_state, mem_re, mem_addr, res_valid, res_out, res_sum
   );

   modport slave (
      output start, num_chunks, thresh, mem_xi, mem_wi, res_ready,
      input  busy, dbg_state, mem_re, mem_addr, res_valid, res_out, res_sum
   );
endinterface

// File: rtl/xnor_pop_sequencer.sv
// Binary-neuron sequencer: reads K chunks, XNOR-popcounts and accumulates them,
// thresholds the total. Define XNOR_SEQ_PERF_EN to add the perf_cycles counter.
module xnor_pop_sequencer #(
   parameter int N      = 256,
   parameter int POP    = 16,
   parameter int AW     = 3,
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic rstn,
`ifdef XNOR_SEQ_PERF_EN
   output logic [15:0] perf_cycles,
`endif
   xnor_pop_sequencer_if.master io
);
   localparam int PW = $clog2(N) + 1;
   localparam logic [AW:0] K_MAX = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t         state_q, state_d;
   logic [AW:0]    k_q;
   logic [AW:0]    cnt_q;
   logic [POP-1:0] thr_q;
   logic [RD_LAT-1:0] tag_q;
   logic           s1_valid_q;
   logic [PW-1:0]  s1_pop_q;
   logic [POP-1:0] acc_q;
   logic [POP-1:0] sum_q;
   logic           out_q;

   logic [AW:0]    k_clamped;
   logic           last_issue;
   logic           drained;
   logic           accept;
   logic           finish;
   logic [N-1:0]   xnor_v;
   logic [PW-1:0]  pop_c;
   logic [POP:0]   acc_sum;
   logic [POP-1:0] acc_next;

   assign k_clamped  = (io.num_chunks > K_MAX) ? K_MAX : io.num_chunks;
   assign last_issue = (cnt_q == (k_q - ONE));
   assign drained    = ~(|tag_q) & ~s1_valid_q;

   // K=0 passes through DRAIN with nothing in flight, giving the one-cycle
   // result latency without a separate path.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (io.start) begin
               accept  = 1'b1;
               state_d = (k_clamped == '0) ? DRAIN : ISSUE;
            end
         end
         ISSUE: if (last_issue) state_d = DRAIN;
         DRAIN: begin
            if (drained) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: if (io.res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign io.busy      = (state_q != IDLE);
   assign io.mem_re    = (state_q == ISSUE);
   assign io.mem_addr  = (state_q == ISSUE) ? cnt_q[AW-1:0] : '0;
   assign io.res_valid = (state_q == DONE);
   assign io.res_sum   = sum_q;
   assign io.res_out   = out_q;
   assign io.dbg_state = state_q;

   always_comb begin
      xnor_v = ~(io.mem_xi ^ io.mem_wi);
      pop_c  = '0;
      for (int i = 0; i < N; i++) pop_c = pop_c + PW'(xnor_v[i]);
   end

   assign acc_sum  = {1'b0, acc_q} + (POP+1)'(s1_pop_q);
   assign acc_next = acc_sum[POP] ? '1 : acc_sum[POP-1:0];

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q    <= IDLE;
         k_q        <= '0;
         cnt_q      <= '0;
         thr_q      <= '0;
         tag_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_pop_q   <= '0;
         acc_q      <= '0;
         sum_q      <= '0;
         out_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         // Each issue is tagged; the tag reaches the top exactly when its data is on the bus.
         tag_q[0] <= io.mem_re;
         for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
         s1_valid_q <= tag_q[RD_LAT-1];
         if (tag_q[RD_LAT-1]) s1_pop_q <= pop_c;
         if (accept) begin
            k_q   <= k_clamped;
            thr_q <= io.thresh;
            acc_q <= '0;
            cnt_q <= '0;
         end else begin
            if (s1_valid_q) acc_q <= acc_next;
            if (state_q == ISSUE) cnt_q <= cnt_q + ONE;
         end
         if (finish) begin
            sum_q <= acc_q;
            out_q <= (acc_q > thr_q);
         end
      end
   end

`ifdef XNOR_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (rstn) begin
         perf_cycles <= '0;
      end else if (accept) begin
         perf_cycles <= '0;
      end else if (((state_q == ISSUE) || (state_q == DRAIN)) && (perf_cycles != 16'hFFFF)) begin
         perf_cycles <= perf_cycles + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_xnor_pop_sequencer.sv
// Directed bench for xnor_pop_sequencer with a fixed-latency chunk buffer model.
module tb_xnor_pop_sequencer;
   localparam int N      = 256;
   localparam int POP    = 16;
   localparam int AW     = 3;
   localparam int RD_LAT = 2;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   xnor_pop_sequencer_if #(.N(N), .POP(POP), .AW(AW)) io ();
`ifdef XNOR_SEQ_PERF_EN
   logic [15:0] perf_cycles;
`endif

   xnor_pop_sequencer #(.N(N), .POP(POP), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk        (clk),
      .rstn       (rstn),
`ifdef XNOR_SEQ_PERF_EN
      .perf_cycles(perf_cycles),
`endif
      .io         (io.master)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int lat;

   logic [N-1:0]  xi_mem [1<<AW];
   logic [N-1:0]  wi_mem [1<<AW];
   logic [AW-1:0] rd_addr_q [$];
   int            rd_cyc_q [$];
   logic [AW-1:0] exp_q [$];
   bit            pv [RD_LAT];
   bit [AW-1:0]   pa [RD_LAT];

   function automatic logic [N-1:0] rand_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N/32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [N-1:0] ones_mask(input int p);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = (i < p);
      return m;
   endfunction

   // Chunk whose XNOR popcount is exactly p.
   task automatic set_chunk(input int idx, input int p);
      xi_mem[idx] = rand_vec();
      wi_mem[idx] = xi_mem[idx] ^ ~ones_mask(p);
   endtask

   // Buffer model: address captured with mem_re is answered RD_LAT cycles later;
   // random garbage is driven whenever no return is due.
   always @(negedge clk) begin
      bit          out_v;
      bit [AW-1:0] out_a;
      cyc++;
      if (io.mem_re === 1'b1) begin
         rd_addr_q.push_back(io.mem_addr);
         rd_cyc_q.push_back(cyc);
      end
      out_v = pv[RD_LAT-1];
      out_a = pa[RD_LAT-1];
      for (int i = RD_LAT-1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pa[i] = pa[i-1];
      end
      pv[0] = (io.mem_re === 1'b1);
      pa[0] = io.mem_addr;
      if (out_v) begin
         io.mem_xi = xi_mem[out_a];
         io.mem_wi = wi_mem[out_a];
      end else begin
         io.mem_xi = rand_vec();
         io.mem_wi = rand_vec();
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(output int l);
      l = -1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk);
         #1;
         if (io.res_valid === 1'b1) begin
            l = e;
            break;
         end
      end
   endtask

   task automatic run_eval(input logic [AW:0] k, input logic [POP-1:0] thr, output int l);
      @(negedge clk);
      io.num_chunks = k;
      io.thresh     = thr;
      io.start      = 1'b1;
      @(posedge clk);
      #1;
      io.start = 1'b0;
      rd_addr_q.delete();
      rd_cyc_q.delete();
      check("busy_after_start", io.busy, 1);
      wait_valid(l);
   endtask

   task automatic check_reads(input string tag, input int k);
      exp_q.delete();
      for (int i = 0; i < k; i++) exp_q.push_back(AW'(i));
      check({tag, "_nreads"}, rd_addr_q.size(), k);
      for (int i = 0; i < k && i < rd_addr_q.size(); i++)
         check({tag, "_addr"}, rd_addr_q[i], exp_q[i]);
      if (k > 0 && rd_cyc_q.size() == k)
         check({tag, "_consecutive"}, rd_cyc_q[k-1] - rd_cyc_q[0], k - 1);
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      io.res_ready = 1'b1;
      @(posedge clk);
      #1;
      io.res_ready = 1'b0;
      check({tag, "_valid_cleared"}, io.res_valid, 0);
      check({tag, "_idle"}, io.busy, 0);
   endtask

   initial begin
      rstn          = 1'b1;
      io.start      = 1'b0;
      io.num_chunks = '0;
      io.thresh     = '0;
      io.res_ready  = 1'b0;
      for (int i = 0; i < (1<<AW); i++) set_chunk(i, 0);

      repeat (3) @(posedge clk);
      #1;
      check("rst_state", io.dbg_state, 0);
      check("rst_busy", io.busy, 0);
      check("rst_mem_re", io.mem_re, 0);
      check("rst_mem_addr", io.mem_addr, 0);
      check("rst_res_valid", io.res_valid, 0);
      check("rst_res_out", io.res_out, 0);
      check("rst_res_sum", io.res_sum, 0);
`ifdef XNOR_SEQ_PERF_EN
      check("rst_perf", perf_cycles, 0);
`endif
      @(negedge clk);
      rstn = 1'b0;

      // K=1, all-ones chunk: pop 256 against 255
      xi_mem[0] = '1;
      wi_mem[0] = '1;
      run_eval(4'd1, 16'd255, lat);
      check("k1_latency", lat, 5);
      check("k1_sum", io.res_sum, 256);
      check("k1_out", io.res_out, 1);
      check_reads("k1", 1);
`ifdef XNOR_SEQ_PERF_EN
      check("k1_perf", perf_cycles, 5);
`endif
      handshake("k1_hs");

      // K=8, xi = ~wi everywhere
      for (int i = 0; i < 8; i++) begin
         xi_mem[i] = rand_vec();
         wi_mem[i] = ~xi_mem[i];
      end
      run_eval(4'd8, 16'd0, lat);
      check("k8_latency", lat, 12);
      check("k8_sum", io.res_sum, 0);
      check("k8_out", io.res_out, 0);
      check_reads("k8", 8);
`ifdef XNOR_SEQ_PERF_EN
      check("k8_perf", perf_cycles, 12);
`endif
      handshake("k8_hs");

      // K=3, pops 100/50/6: threshold equal then one below
      set_chunk(0, 100);
      set_chunk(1, 50);
      set_chunk(2, 6);
      run_eval(4'd3, 16'd156, lat);
      check("k3a_latency", lat, 7);
      check("k3a_sum", io.res_sum, 156);
      check("k3a_out", io.res_out, 0);
      check_reads("k3a", 3);
      handshake("k3a_hs");
      run_eval(4'd3, 16'd155, lat);
      check("k3b_sum", io.res_sum, 156);
      check("k3b_out", io.res_out, 1);
      handshake("k3b_hs");

      // Backpressure: K=2 pops 30/40, ready low 5 cycles, start pulse in cycle 2
      set_chunk(0, 30);
      set_chunk(1, 40);
      run_eval(4'd2, 16'd100, lat);
      check("bp_latency", lat, 6);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         io.start      = (c == 2);
         io.num_chunks = 4'd1;
         io.thresh     = 16'd5;
         @(posedge clk);
         #1;
         check("bp_valid_held", io.res_valid, 1);
         check("bp_sum_held", io.res_sum, 70);
         check("bp_out_held", io.res_out, 0);
         check("bp_state_done", io.dbg_state, 3);
      end
      // start together with the handshake edge must not be taken
      @(negedge clk);
      io.start     = 1'b1;
      io.res_ready = 1'b1;
      @(posedge clk);
      #1;
      io.res_ready = 1'b0;
      check("bp_hs_valid", io.res_valid, 0);
      check("bp_hs_start_ignored", io.busy, 0);
      check("bp_idle_sum_kept", io.res_sum, 70);
      @(posedge clk);
      #1;
      io.start = 1'b0;
      rd_addr_q.delete();
      rd_cyc_q.delete();
      check("bp_next_start_taken", io.busy, 1);
      wait_valid(lat);
      check("bp_next_latency", lat, 5);
      check("bp_next_sum", io.res_sum, 30);
      check("bp_next_out", io.res_out, 1);
      handshake("bp_next_hs");

      // K=0: one-cycle result, no reads
      run_eval(4'd0, 16'd0, lat);
      check("k0_latency", lat, 1);
      check("k0_sum", io.res_sum, 0);
      check("k0_out", io.res_out, 0);
      check_reads("k0", 0);
      handshake("k0_hs");

      // K=9 clamps to 8 reads; pops 1..8 sum to 36
      for (int i = 0; i < 8; i++) set_chunk(i, i + 1);
      run_eval(4'd9, 16'd40, lat);
      check("k9_latency", lat, 12);
      check("k9_sum", io.res_sum, 36);
      check("k9_out", io.res_out, 0);
      check_reads("k9", 8);
      handshake("k9_hs");

      // Reset during DRAIN of a K=4 run, then a clean K=1 run
      for (int i = 0; i < 4; i++) set_chunk(i, 200);
      @(negedge clk);
      io.num_chunks = 4'd4;
      io.thresh     = 16'd0;
      io.start      = 1'b1;
      @(posedge clk);
      #1;
      io.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst4_in_drain", io.dbg_state, 2);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      rstn = 1'b0;
      check("rst4_busy", io.busy, 0);
      check("rst4_sum_cleared", io.res_sum, 0);
      set_chunk(0, 10);
      run_eval(4'd1, 16'd5, lat);
      check("post_rst_latency", lat, 5);
      check("post_rst_sum", io.res_sum, 10);
      check("post_rst_out", io.res_out, 1);
      check_reads("post_rst", 1);
`ifdef XNOR_SEQ_PERF_EN
      check("post_rst_perf", perf_cycles, 5);
`endif
      handshake("post_rst_hs");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
